// File: rtl/axi4lite_pkg.sv
// rtl/axi4lite_pkg.sv - shared types and address helper for the AXI4-Lite register file
package axi4lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RESP = 1'b1
    } rd_state_t;

    // Word index of a byte address: the byte-lane bits are dropped so
    // unaligned addresses fold onto the containing word.
    function automatic int unsigned word_idx(input logic [63:0] addr,
                                             input int unsigned addr_w,
                                             input int unsigned data_w);
        logic [63:0] masked;
        int unsigned lsb;
        lsb    = (data_w == 64) ? 3 : 2;
        masked = (addr_w >= 64) ? addr : (addr & ((64'd1 << addr_w) - 64'd1));
        return 32'(masked >> lsb);
    endfunction

endpackage

// File: rtl/axi4lite_wr_join.sv
// rtl/axi4lite_wr_join.sv - joins independent AW and W handshakes into one write commit
//
// Ports:
//   clk, rstn                    clock, synchronous active-low reset
//   aw_addr/aw_valid/aw_ready    write-address channel
//   w_data/w_strb/w_valid/w_ready write-data channel
//   b_valid                      pending write response (blocks new acceptance)
//   active                       high from the first edge after reset release
//   commit                       address and data both available this edge
//   commit_addr/data/strb        the joined write, valid while commit is high
module axi4lite_wr_join #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ADDR_W-1:0]     aw_addr,
    input  logic                  aw_valid,
    output logic                  aw_ready,
    input  logic [DATA_W-1:0]     w_data,
    input  logic [DATA_W/8-1:0]   w_strb,
    input  logic                  w_valid,
    output logic                  w_ready,
    input  logic                  b_valid,
    output logic                  active,
    output logic                  commit,
    output logic [ADDR_W-1:0]     commit_addr,
    output logic [DATA_W-1:0]     commit_data,
    output logic [DATA_W/8-1:0]   commit_strb
);

    logic                active_q;
    logic                aw_held;
    logic                w_held;
    logic [ADDR_W-1:0]   aw_addr_q;
    logic [DATA_W-1:0]   w_data_q;
    logic [DATA_W/8-1:0] w_strb_q;
    logic                aw_hs;
    logic                w_hs;

    assign active   = active_q;
    assign aw_ready = active_q & ~aw_held & ~b_valid;
    assign w_ready  = active_q & ~w_held & ~b_valid;
    assign aw_hs    = aw_valid & aw_ready;
    assign w_hs     = w_valid & w_ready;

    // A side is available if it was held earlier or handshakes on this edge.
    assign commit      = (aw_held | aw_hs) & (w_held | w_hs);
    assign commit_addr = aw_held ? aw_addr_q : aw_addr;
    assign commit_data = w_held ? w_data_q : w_data;
    assign commit_strb = w_held ? w_strb_q : w_strb;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            active_q  <= 1'b0;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            active_q <= 1'b1;
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end else begin
                if (aw_hs) begin
                    aw_held   <= 1'b1;
                    aw_addr_q <= aw_addr;
                end
                if (w_hs) begin
                    w_held   <= 1'b1;
                    w_data_q <= w_data;
                    w_strb_q <= w_strb;
                end
            end
        end
    end

endmodule

// File: rtl/axi4lite_regfile_slave.sv
// rtl/axi4lite_regfile_slave.sv - parametrised AXI4-Lite slave register file
//
// Ports:
//   A_CLK, A_RSTn            clock, synchronous active-low reset
//   AW_*, W_*, B_*           AXI4-Lite write address / data / response channels
//   AR_*, R_*                AXI4-Lite read address / data channels
//   hw_status_i              read-only register sources, slot i at [i*DATA_W +: DATA_W]
//   regs_o                   stored register values, read-only slots drive 0
//   wr_pulse_o               one-cycle strobe per register after an OKAY write
import axi4lite_pkg::*;

module axi4lite_regfile_slave #(
    parameter int                   ADDR_W    = 8,
    parameter int                   DATA_W    = 32,
    parameter int                   NUM_REGS  = 16,
    parameter logic [NUM_REGS-1:0]  RO_MASK   = '0,
    parameter logic [DATA_W-1:0]    RESET_VAL = '0
) (
    input  logic                         A_CLK,
    input  logic                         A_RSTn,
    input  logic [ADDR_W-1:0]            AW_ADDR,
    input  logic                         AW_VALID,
    output logic                         AW_READY,
    input  logic [DATA_W-1:0]            W_DATA,
    input  logic [DATA_W/8-1:0]          W_STRB,
    input  logic                         W_VALID,
    output logic                         W_READY,
    output logic [1:0]                   B_RESP,
    output logic                         B_VALID,
    input  logic                         B_READY,
    input  logic [ADDR_W-1:0]            AR_ADDR,
    input  logic                         AR_VALID,
    output logic                         AR_READY,
    output logic [DATA_W-1:0]            R_DATA,
    output logic [1:0]                   R_RESP,
    output logic                         R_VALID,
    input  logic                         R_READY,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_status_i,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o,
    output logic [NUM_REGS-1:0]          wr_pulse_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic                active;
    logic                commit;
    logic [ADDR_W-1:0]   c_addr;
    logic [DATA_W-1:0]   c_data;
    logic [STRB_W-1:0]   c_strb;

    logic                b_valid_q;
    resp_t               b_resp_q;
    logic [NUM_REGS-1:0] wr_pulse_q;

    int unsigned         wr_idx;
    logic [IDX_W-1:0]    wr_sel;
    resp_t               wr_resp;
    logic                wr_en;

    rd_state_t           rd_state;
    rd_state_t           rd_next;
    logic                ar_hs;
    int unsigned         rd_idx;
    logic [IDX_W-1:0]    rd_sel;
    resp_t               rd_resp_d;
    logic [DATA_W-1:0]   rd_data_d;
    resp_t               r_resp_q;
    logic [DATA_W-1:0]   r_data_q;

    logic [DATA_W-1:0]   reg_val [NUM_REGS];

    axi4lite_wr_join #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_wr_join (
        .clk         (A_CLK),
        .rstn        (A_RSTn),
        .aw_addr     (AW_ADDR),
        .aw_valid    (AW_VALID),
        .aw_ready    (AW_READY),
        .w_data      (W_DATA),
        .w_strb      (W_STRB),
        .w_valid     (W_VALID),
        .w_ready     (W_READY),
        .b_valid     (b_valid_q),
        .active      (active),
        .commit      (commit),
        .commit_addr (c_addr),
        .commit_data (c_data),
        .commit_strb (c_strb)
    );

    // Write decode
    always_comb begin
        wr_idx  = word_idx(64'(c_addr), ADDR_W, DATA_W);
        wr_sel  = wr_idx[IDX_W-1:0];
        wr_resp = OKAY;
        if (wr_idx >= 32'(NUM_REGS)) begin
            wr_resp = DECERR;
        end else if (RO_MASK[wr_sel]) begin
            wr_resp = SLVERR;
        end
    end

    assign wr_en = commit & (wr_resp == OKAY);

    // Storage: read-only slots have no flops and present hw_status_i instead.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (RO_MASK[i]) begin : g_ro
            assign reg_val[i]                   = hw_status_i[i*DATA_W +: DATA_W];
            assign regs_o[i*DATA_W +: DATA_W]   = '0;
        end else begin : g_rw
            logic [DATA_W-1:0] store_q;
            logic              unused_hw;
            always_ff @(posedge A_CLK) begin
                if (!A_RSTn) begin
                    store_q <= RESET_VAL;
                end else if (wr_en && (wr_sel == IDX_W'(i))) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (c_strb[b]) store_q[b*8 +: 8] <= c_data[b*8 +: 8];
                    end
                end
            end
            assign reg_val[i]                 = store_q;
            assign regs_o[i*DATA_W +: DATA_W] = store_q;
            assign unused_hw                  = ^hw_status_i[i*DATA_W +: DATA_W];
        end
    end

    // Write response and commit strobe
    always_ff @(posedge A_CLK) begin
        if (!A_RSTn) begin
            b_valid_q  <= 1'b0;
            b_resp_q   <= OKAY;
            wr_pulse_q <= '0;
        end else begin
            wr_pulse_q <= '0;
            if (wr_en) wr_pulse_q[wr_sel] <= 1'b1;
            // commit needs a handshake, which B_VALID blocks, so the two never collide
            if (commit) begin
                b_valid_q <= 1'b1;
                b_resp_q  <= wr_resp;
            end else if (b_valid_q && B_READY) begin
                b_valid_q <= 1'b0;
            end
        end
    end

    assign B_VALID    = b_valid_q;
    assign B_RESP     = b_resp_q;
    assign wr_pulse_o = wr_pulse_q;

    // Read path
    assign AR_READY = active & (rd_state == RD_IDLE);
    assign ar_hs    = AR_VALID & AR_READY;
    assign R_VALID  = (rd_state == RD_RESP);

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            RD_IDLE: if (ar_hs) rd_next = RD_RESP;
            RD_RESP: if (R_READY) rd_next = RD_IDLE;
            default: rd_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge A_CLK) begin
        if (!A_RSTn) rd_state <= RD_IDLE;
        else         rd_state <= rd_next;
    end

    always_comb begin
        rd_idx    = word_idx(64'(AR_ADDR), ADDR_W, DATA_W);
        rd_sel    = rd_idx[IDX_W-1:0];
        rd_resp_d = OKAY;
        rd_data_d = '0;
        if (rd_idx >= 32'(NUM_REGS)) begin
            rd_resp_d = DECERR;
        end else begin
            rd_data_d = reg_val[rd_sel];
        end
    end

    // Captured from pre-edge storage, so a same-edge write is not visible.
    always_ff @(posedge A_CLK) begin
        if (!A_RSTn) begin
            r_data_q <= '0;
            r_resp_q <= OKAY;
        end else if (ar_hs) begin
            r_data_q <= rd_data_d;
            r_resp_q <= rd_resp_d;
        end
    end

    assign R_DATA = r_data_q;
    assign R_RESP = r_resp_q;

endmodule

// File: tb/tb_axi4lite_regfile_slave.sv
// tb/tb_axi4lite_regfile_slave.sv - self-checking bench for axi4lite_regfile_slave
module tb_axi4lite_regfile_slave;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;

    logic                        A_CLK;
    logic                        A_RSTn;
    logic [ADDR_W-1:0]           AW_ADDR;
    logic                        AW_VALID;
    logic                        AW_READY;
    logic [DATA_W-1:0]           W_DATA;
    logic [3:0]                  W_STRB;
    logic                        W_VALID;
    logic                        W_READY;
    logic [1:0]                  B_RESP;
    logic                        B_VALID;
    logic                        B_READY;
    logic [ADDR_W-1:0]           AR_ADDR;
    logic                        AR_VALID;
    logic                        AR_READY;
    logic [DATA_W-1:0]           R_DATA;
    logic [1:0]                  R_RESP;
    logic                        R_VALID;
    logic                        R_READY;
    logic [NUM_REGS*DATA_W-1:0]  hw_status;
    logic [NUM_REGS*DATA_W-1:0]  regs_o;
    logic [NUM_REGS-1:0]         wr_pulse_o;

    axi4lite_regfile_slave #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .NUM_REGS  (NUM_REGS),
        .RO_MASK   (16'h8000),
        .RESET_VAL (32'h0)
    ) dut (
        .A_CLK       (A_CLK),
        .A_RSTn      (A_RSTn),
        .AW_ADDR     (AW_ADDR),
        .AW_VALID    (AW_VALID),
        .AW_READY    (AW_READY),
        .W_DATA      (W_DATA),
        .W_STRB      (W_STRB),
        .W_VALID     (W_VALID),
        .W_READY     (W_READY),
        .B_RESP      (B_RESP),
        .B_VALID     (B_VALID),
        .B_READY     (B_READY),
        .AR_ADDR     (AR_ADDR),
        .AR_VALID    (AR_VALID),
        .AR_READY    (AR_READY),
        .R_DATA      (R_DATA),
        .R_RESP      (R_RESP),
        .R_VALID     (R_VALID),
        .R_READY     (R_READY),
        .hw_status_i (hw_status),
        .regs_o      (regs_o),
        .wr_pulse_o  (wr_pulse_o)
    );

    initial A_CLK = 1'b0;
    always #5 A_CLK = ~A_CLK;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem [16];
    logic [31:0] hw15;
    int          exp_pulse [16];
    int          pulse_cnt [16];

    always @(negedge A_CLK) begin
        for (int i = 0; i < 16; i++) pulse_cnt[i] += int'(wr_pulse_o[i]);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_hw15(input logic [31:0] v);
        hw15 = v;
        hw_status[15*32 +: 32] = v;
    endtask

    // Reference model: word-addressed array, slot 15 read-only, 16 slots total.
    function automatic logic [1:0] model_write(input logic [7:0] addr, input logic [31:0] data,
                                               input logic [3:0] strb);
        int idx;
        idx = int'(addr) / 4;
        if (idx >= 16) return 2'b11;
        if (idx == 15) return 2'b10;
        for (int b = 0; b < 4; b++)
            if (strb[b]) mem[idx][b*8 +: 8] = data[b*8 +: 8];
        exp_pulse[idx]++;
        return 2'b00;
    endfunction

    task automatic model_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int idx;
        idx = int'(addr) / 4;
        resp = 2'b00;
        if (idx >= 16) begin
            data = 32'h0;
            resp = 2'b11;
        end else if (idx == 15) begin
            data = hw15;
        end else begin
            data = mem[idx];
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int da, input int dw, input int bdly, output logic [1:0] resp);
        bit aw_done, w_done, aw_go, w_go;
        int c, n;
        aw_done = 0; w_done = 0; c = 0;
        AW_ADDR = addr; W_DATA = data; W_STRB = strb;
        while (!(aw_done && w_done) && c < 40) begin
            @(negedge A_CLK);
            AW_VALID = !aw_done && (c >= da);
            W_VALID  = !w_done && (c >= dw);
            aw_go = AW_VALID && AW_READY;
            w_go  = W_VALID && W_READY;
            @(posedge A_CLK);
            aw_done |= aw_go;
            w_done  |= w_go;
            c++;
        end
        @(negedge A_CLK);
        AW_VALID = 1'b0;
        W_VALID  = 1'b0;
        if (!(aw_done && w_done)) chk("wr_handshake_timeout", 64'(c), 64'(0));
        n = 0;
        while (!B_VALID && n < 20) begin
            @(negedge A_CLK);
            n++;
        end
        if (!B_VALID) chk("bvalid_timeout", 64'(B_VALID), 64'(1));
        resp = B_RESP;
        repeat (bdly) @(negedge A_CLK);
        B_READY = 1'b1;
        @(negedge A_CLK);
        B_READY = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] addr, input int rdly,
                            output logic [31:0] data, output logic [1:0] resp);
        int n;
        @(negedge A_CLK);
        AR_ADDR  = addr;
        AR_VALID = 1'b1;
        n = 0;
        while (!AR_READY && n < 20) begin
            @(negedge A_CLK);
            n++;
        end
        if (!AR_READY) chk("ar_handshake_timeout", 64'(AR_READY), 64'(1));
        @(posedge A_CLK);
        @(negedge A_CLK);
        AR_VALID = 1'b0;
        n = 0;
        while (!R_VALID && n < 20) begin
            @(negedge A_CLK);
            n++;
        end
        if (!R_VALID) chk("rvalid_timeout", 64'(R_VALID), 64'(1));
        data = R_DATA;
        resp = R_RESP;
        repeat (rdly) @(negedge A_CLK);
        R_READY = 1'b1;
        @(negedge A_CLK);
        R_READY = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic [1:0]  resp, eresp;
        logic [31:0] rdata, edata;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;

        A_RSTn = 1'b0;
        AW_ADDR = '0; AW_VALID = 1'b0; W_DATA = '0; W_STRB = '0; W_VALID = 1'b0;
        B_READY = 1'b0; AR_ADDR = '0; AR_VALID = 1'b0; R_READY = 1'b0;
        hw_status = '0;
        set_hw15(32'hCAFEF00D);
        model_reset();

        vecs.push_back('{1'b0, 8'h04, 32'h0,        4'h0, 2'b00, 32'h0});
        vecs.push_back('{1'b1, 8'h08, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0});
        vecs.push_back('{1'b1, 8'h08, 32'h000000AA, 4'h1, 2'b00, 32'h0});
        vecs.push_back('{1'b0, 8'h08, 32'h0,        4'h0, 2'b00, 32'hDEADBEAA});
        vecs.push_back('{1'b1, 8'h3C, 32'h11111111, 4'hF, 2'b10, 32'h0});
        vecs.push_back('{1'b0, 8'h3C, 32'h0,        4'h0, 2'b00, 32'hCAFEF00D});
        vecs.push_back('{1'b0, 8'h40, 32'h0,        4'h0, 2'b11, 32'h0});
        vecs.push_back('{1'b1, 8'h80, 32'h77777777, 4'hF, 2'b11, 32'h0});
        vecs.push_back('{1'b0, 8'h0A, 32'h0,        4'h0, 2'b00, 32'hDEADBEAA});
        vecs.push_back('{1'b1, 8'h0C, 32'hFFFFFFFF, 4'h0, 2'b00, 32'h0});
        vecs.push_back('{1'b0, 8'h0C, 32'h0,        4'h0, 2'b00, 32'h0});
        vecs.push_back('{1'b1, 8'h1F, 32'hA5A5A5A5, 4'hC, 2'b00, 32'h0});
        vecs.push_back('{1'b0, 8'h1C, 32'h0,        4'h0, 2'b00, 32'hA5A50000});

        // Reset state
        repeat (3) @(negedge A_CLK);
        chk("rst_readys", 64'({AW_READY, W_READY, AR_READY}), 64'(0));
        chk("rst_valids", 64'({B_VALID, R_VALID}), 64'(0));
        chk("rst_resps", 64'({B_RESP, R_RESP}), 64'(0));
        chk("rst_rdata", 64'(R_DATA), 64'(0));
        chk("rst_regs", 64'(|regs_o), 64'(0));
        chk("rst_pulse", 64'(wr_pulse_o), 64'(0));
        A_RSTn = 1'b1;
        @(negedge A_CLK);
        chk("first_cycle_readys", 64'({AW_READY, W_READY, AR_READY}), 64'(3'b111));

        // Directed vector table
        foreach (vecs[k]) begin
            if (vecs[k].wr) begin
                axi_write(vecs[k].addr, vecs[k].data, vecs[k].strb, 0, 0, 0, resp);
                void'(model_write(vecs[k].addr, vecs[k].data, vecs[k].strb));
                chk($sformatf("vec%0d_bresp", k), 64'(resp), 64'(vecs[k].resp));
            end else begin
                axi_read(vecs[k].addr, 0, rdata, resp);
                chk($sformatf("vec%0d_rresp", k), 64'(resp), 64'(vecs[k].resp));
                chk($sformatf("vec%0d_rdata", k), 64'(rdata), 64'(vecs[k].rdata));
            end
        end
        chk("regs_o_slot2", 64'(regs_o[2*32 +: 32]), 64'(32'hDEADBEAA));
        chk("regs_o_slot3", 64'(regs_o[3*32 +: 32]), 64'(32'h0));
        chk("regs_o_slot15_ro", 64'(regs_o[15*32 +: 32]), 64'(32'h0));
        chk("pulse_slot2_twice", 64'(pulse_cnt[2]), 64'(2));
        chk("pulse_slot15_none", 64'(pulse_cnt[15]), 64'(0));

        // W first, AW three cycles later
        @(negedge A_CLK);
        W_DATA = 32'h12345678; W_STRB = 4'hF; W_VALID = 1'b1;
        chk("wfirst_w_ready", 64'(W_READY), 64'(1));
        @(negedge A_CLK);
        W_VALID = 1'b0;
        chk("wfirst_w_ready_held", 64'(W_READY), 64'(0));
        chk("wfirst_aw_ready_wait", 64'(AW_READY), 64'(1));
        chk("wfirst_no_bvalid", 64'(B_VALID), 64'(0));
        @(negedge A_CLK);
        @(negedge A_CLK);
        AW_ADDR = 8'h10; AW_VALID = 1'b1;
        chk("wfirst_aw_ready_pre", 64'(AW_READY), 64'(1));
        @(negedge A_CLK);
        AW_VALID = 1'b0;
        chk("wfirst_bvalid", 64'({B_VALID, B_RESP}), 64'(3'b100));
        chk("wfirst_readys_low", 64'({AW_READY, W_READY}), 64'(0));
        chk("wfirst_regs_o", 64'(regs_o[4*32 +: 32]), 64'(32'h12345678));
        chk("wfirst_pulse", 64'(wr_pulse_o), 64'(16'h0010));
        void'(model_write(8'h10, 32'h12345678, 4'hF));
        B_READY = 1'b1;
        @(negedge A_CLK);
        B_READY = 1'b0;
        chk("wfirst_after_b", 64'({AW_READY, W_READY, B_VALID}), 64'(3'b110));

        // R_READY stall with a second AR pending
        @(negedge A_CLK);
        AR_ADDR = 8'h08; AR_VALID = 1'b1;
        @(negedge A_CLK);
        AR_ADDR = 8'h10;
        model_read(8'h08, edata, eresp);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall%0d_rdata", c), 64'(R_DATA), 64'(edata));
            chk($sformatf("stall%0d_ar_rv", c), 64'({AR_READY, R_VALID}), 64'(2'b01));
            @(negedge A_CLK);
        end
        R_READY = 1'b1;
        @(negedge A_CLK);
        R_READY = 1'b0;
        chk("stall_ar_ready_back", 64'({AR_READY, R_VALID}), 64'(2'b10));
        @(negedge A_CLK);
        AR_VALID = 1'b0;
        model_read(8'h10, edata, eresp);
        chk("second_read_valid", 64'({R_VALID, R_RESP}), 64'({1'b1, eresp}));
        chk("second_read_data", 64'(R_DATA), 64'(edata));
        R_READY = 1'b1;
        @(negedge A_CLK);
        R_READY = 1'b0;

        // Randomised traffic against the model
        for (int n = 0; n < 60; n++) begin
            addr = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(0, 8'h43)) : 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                data = $urandom;
                strb = 4'($urandom_range(0, 15));
                eresp = model_write(addr, data, strb);
                axi_write(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 2), resp);
                chk($sformatf("rnd%0d_bresp", n), 64'(resp), 64'(eresp));
            end else begin
                if ($urandom_range(0, 3) == 0) set_hw15($urandom);
                model_read(addr, edata, eresp);
                axi_read(addr, $urandom_range(0, 2), rdata, resp);
                chk($sformatf("rnd%0d_rresp", n), 64'(resp), 64'(eresp));
                chk($sformatf("rnd%0d_rdata", n), 64'(rdata), 64'(edata));
            end
        end
        for (int i = 0; i < 16; i++)
            chk($sformatf("final_regs_o%0d", i), 64'(regs_o[i*32 +: 32]), 64'((i == 15) ? 32'h0 : mem[i]));

        // Reset while a write response is pending
        @(negedge A_CLK);
        AW_ADDR = 8'h00; AW_VALID = 1'b1; W_DATA = 32'h55; W_STRB = 4'hF; W_VALID = 1'b1;
        @(negedge A_CLK);
        AW_VALID = 1'b0; W_VALID = 1'b0;
        void'(model_write(8'h00, 32'h55, 4'hF));
        chk("rstmid_bvalid_pending", 64'(B_VALID), 64'(1));
        A_RSTn = 1'b0;
        @(negedge A_CLK);
        model_reset();
        chk("rstmid_bvalid_cleared", 64'(B_VALID), 64'(0));
        chk("rstmid_regs_cleared", 64'(|regs_o), 64'(0));
        chk("rstmid_readys_low", 64'({AW_READY, W_READY, AR_READY}), 64'(0));
        repeat (2) @(negedge A_CLK);
        A_RSTn = 1'b1;
        @(negedge A_CLK);
        chk("rstmid_after_release", 64'({AW_READY, W_READY, B_VALID}), 64'(3'b110));
        axi_read(8'h00, 0, rdata, resp);
        chk("rstmid_read0", 64'({resp, rdata}), 64'(0));

        repeat (3) @(negedge A_CLK);
        for (int i = 0; i < 16; i++)
            chk($sformatf("pulse_count%0d", i), 64'(pulse_cnt[i]), 64'(exp_pulse[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
